// File: rtl/add2_operand_stage_if.sv
// ============================================================================
//  Module      : add2_operand_stage_if
//  Description : Bundles the operand handshake, the ADD2 adder connection and
//                the result handshake of add2_operand_stage.
//                slave  - the operand stage itself
//                master - the environment (producer, ADD2 adder, consumer)
//  Ports (signals)
//    opValid/opReady/opA/opB   operand pair handshake (producer -> stage)
//    addIn1/addIn0/sum         stage <-> combinational ADD2 adder
//    resValid/resReady/resSum  result handshake (stage -> consumer)
//    level                     FIFO occupancy 0..DEPTH
//    resOvf                    carry-out of the held result; present only
//                              when ADD2_OVERFLOW_FLAG_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add2_operand_stage_if #(
    parameter int DEPTH = 4,
    parameter int W     = 2
);
    logic                       opValid;
    logic                       opReady;
    logic [W-1:0]               opA;
    logic [W-1:0]               opB;
    logic [W-1:0]               addIn1;
    logic [W-1:0]               addIn0;
    logic [W-1:0]               sum;
    logic                       resValid;
    logic                       resReady;
    logic [W-1:0]               resSum;
    logic [$clog2(DEPTH+1)-1:0] level;
`ifdef ADD2_OVERFLOW_FLAG_EN
    logic                       resOvf;
`endif

    modport slave (
        input  opValid,
        input  opA,
        input  opB,
        input  sum,
        input  resReady,
        output opReady,
        output addIn1,
        output addIn0,
        output resValid,
        output resSum,
        output level
`ifdef ADD2_OVERFLOW_FLAG_EN
        , output resOvf
`endif
    );

    modport master (
        output opValid,
        output opA,
        output opB,
        output sum,
        output resReady,
        input  opReady,
        input  addIn1,
        input  addIn0,
        input  resValid,
        input  resSum,
        input  level
`ifdef ADD2_OVERFLOW_FLAG_EN
        , input  resOvf
`endif
    );

endinterface

`default_nettype wire

// File: rtl/add2_operand_stage.sv
// ============================================================================
//  Module      : add2_operand_stage
//  Description : Operand/result stage around the combinational ADD2 adder.
//                Operand pairs are buffered in a DEPTH-entry FIFO; the FIFO
//                head drives the adder and the returned sum is captured in a
//                result register handed downstream over valid/ready.
//  Parameters  : DEPTH - FIFO entries, power of 2 in 2..16 (default 4)
//                W     - operand/sum width, tied to ADD2 (default 2)
//  Ports       : clk  - rising-edge clock
//                rstN - asynchronous active-low reset
//                bus  - add2_operand_stage_if.slave (operands, adder, result)
//  Option      : ADD2_OVERFLOW_FLAG_EN - adds bus.resOvf, the carry-out of
//                the captured addition, registered alongside resSum
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add2_operand_stage #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  wire logic           clk,
    input  wire logic           rstN,
    add2_operand_stage_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] C_LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    // FIFO storage: {A, B} per entry
    logic [2*W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;

    // Result register
    state_t           state_q;
    logic             resValid_q;
    logic [W-1:0]     resSum_q;
`ifdef ADD2_OVERFLOW_FLAG_EN
    logic             resOvf_q;
`endif

    logic             w_notEmpty;
    logic             w_push;
    logic             w_pop;
    logic [2*W-1:0]   w_head;

    assign w_notEmpty = (level_q != '0);
    // No bypass: a full FIFO refuses the push even when it pops this cycle.
    assign w_push     = bus.opValid && (level_q != C_LVL_FULL);
    assign w_pop      = w_notEmpty && (!resValid_q || bus.resReady);
    assign w_head     = mem_q[rd_ptr_q];

    // The adder sees zeros whenever there is no valid head.
    assign bus.addIn1   = w_notEmpty ? w_head[2*W-1:W] : '0;
    assign bus.addIn0   = w_notEmpty ? w_head[W-1:0]   : '0;
    assign bus.opReady  = (level_q != C_LVL_FULL);
    assign bus.level    = level_q;
    assign bus.resValid = resValid_q;
    assign bus.resSum   = resSum_q;
`ifdef ADD2_OVERFLOW_FLAG_EN
    assign bus.resOvf   = resOvf_q;
`endif

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; entries are only observed while counted in level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus.opA, bus.opB};
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Result state machine; its capture decisions match w_pop exactly.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= S_EMPTY;
            resValid_q <= 1'b0;
            resSum_q   <= '0;
`ifdef ADD2_OVERFLOW_FLAG_EN
            resOvf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_notEmpty) begin
                        state_q    <= S_FULL;
                        resValid_q <= 1'b1;
                        resSum_q   <= bus.sum;
`ifdef ADD2_OVERFLOW_FLAG_EN
                        resOvf_q   <= (bus.sum < bus.addIn1);
`endif
                    end
                end
                S_FULL: begin
                    if (bus.resReady) begin
                        if (w_notEmpty) begin
                            resSum_q <= bus.sum;
`ifdef ADD2_OVERFLOW_FLAG_EN
                            resOvf_q <= (bus.sum < bus.addIn1);
`endif
                        end else begin
                            // Drained: resSum keeps its last value.
                            state_q    <= S_EMPTY;
                            resValid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= S_EMPTY;
                    resValid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add2_operand_stage.sv
// ============================================================================
//  Module      : tb_add2_operand_stage
//  Description : Directed and streaming checks of add2_operand_stage with a
//                behavioural ADD2 adder driving bus.sum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add2_operand_stage;

    localparam int DEPTH = 4;
    localparam int W     = 2;
    localparam int N_STREAM   = 64;
    localparam int MAX_CYCLES = 3000;

    logic clk;
    logic rstN;

    int n_checks;
    int n_fail;

    add2_operand_stage_if #(.DEPTH(DEPTH), .W(W)) bus ();

    add2_operand_stage #(.DEPTH(DEPTH), .W(W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    // ADD2: combinational sum modulo 2^W
    assign bus.sum = bus.addIn1 + bus.addIn0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input int a, input int b);
        bus.opValid = 1'b1;
        bus.opA     = W'(a);
        bus.opB     = W'(b);
        step();
    endtask

    initial begin
        int exp_q[$];
        int pushed;
        int got;
        int cyc;
        int e;
        int sum_seq[5];

        n_checks = 0;
        n_fail   = 0;
        rstN         = 1'b0;
        bus.opValid  = 1'b0;
        bus.opA      = '0;
        bus.opB      = '0;
        bus.resReady = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_level",    32'(bus.level),    0);
        check("rst_opReady",  32'(bus.opReady),  1);
        check("rst_resValid", 32'(bus.resValid), 0);
        check("rst_resSum",   32'(bus.resSum),   0);
        check("rst_addIn1",   32'(bus.addIn1),   0);
        check("rst_addIn0",   32'(bus.addIn0),   0);
`ifdef ADD2_OVERFLOW_FLAG_EN
        check("rst_resOvf",   32'(bus.resOvf),   0);
`endif
        rstN = 1'b1;
        step();

        // ---------------- single op: 1 + 2 ----------------
        bus.resReady = 1'b1;
        push_pair(1, 2);
        bus.opValid = 1'b0;
        check("single_level1",   32'(bus.level),    1);
        check("single_valid0",   32'(bus.resValid), 0);
        check("single_addIn1",   32'(bus.addIn1),   1);
        check("single_addIn0",   32'(bus.addIn0),   2);
        step();
        check("single_valid1",   32'(bus.resValid), 1);
        check("single_sum",      32'(bus.resSum),   3);
        check("single_level0",   32'(bus.level),    0);
        step();
        check("single_drain",    32'(bus.resValid), 0);
        check("single_hold",     32'(bus.resSum),   3);

        // ---------------- wrap: 3 + 3, then 1 + 1 ----------------
        push_pair(3, 3);
        bus.opValid = 1'b0;
        step();
        check("wrap33_valid", 32'(bus.resValid), 1);
        check("wrap33_sum",   32'(bus.resSum),   2);
`ifdef ADD2_OVERFLOW_FLAG_EN
        check("wrap33_ovf",   32'(bus.resOvf),   1);
`endif
        step();
        push_pair(1, 1);
        bus.opValid = 1'b0;
        step();
        check("wrap11_sum",   32'(bus.resSum),   2);
`ifdef ADD2_OVERFLOW_FLAG_EN
        check("wrap11_ovf",   32'(bus.resOvf),   0);
`endif
        step();
        check("wrap_drain",   32'(bus.resValid), 0);

        // ---------------- backpressure + full simultaneous ----------------
        bus.resReady = 1'b0;
        push_pair(0, 1);
        push_pair(1, 1);
        push_pair(2, 1);
        push_pair(3, 0);
        push_pair(0, 0);
        check("bp_level4",   32'(bus.level),    4);
        check("bp_opReady0", 32'(bus.opReady),  0);
        check("bp_valid",    32'(bus.resValid), 1);
        check("bp_sum0",     32'(bus.resSum),   1);
        // Held result must stay put while resReady is low.
        bus.opValid = 1'b0;
        step();
        check("bp_hold_sum",   32'(bus.resSum), 1);
        check("bp_hold_level", 32'(bus.level),  4);

        // Release while full with a push offered: push refused, level drops.
        bus.resReady = 1'b1;
        bus.opValid  = 1'b1;
        bus.opA      = W'(2);
        bus.opB      = W'(2);
        step();
        check("full_level3",   32'(bus.level),   3);
        check("full_sum1",     32'(bus.resSum),  2);
        check("full_opReady1", 32'(bus.opReady), 1);
        step();
        bus.opValid = 1'b0;
        check("simul_level3",  32'(bus.level),   3);
        check("simul_sum2",    32'(bus.resSum),  3);
        sum_seq[0] = 3;
        sum_seq[1] = 0;
        sum_seq[2] = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_order_valid", 32'(bus.resValid), 1);
            check("bp_order_sum",   32'(bus.resSum),   32'(sum_seq[i]));
        end
        check("bp_level0", 32'(bus.level), 0);
        step();
        check("bp_drain", 32'(bus.resValid), 0);

        // ---------------- reset mid-stream ----------------
        bus.resReady = 1'b0;
        push_pair(1, 0);
        push_pair(2, 0);
        push_pair(3, 0);
        push_pair(0, 1);
        bus.opValid = 1'b0;
        check("mid_pre_level", 32'(bus.level),    3);
        check("mid_pre_valid", 32'(bus.resValid), 1);
        check("mid_pre_sum",   32'(bus.resSum),   1);
        #1;
        rstN = 1'b0;
        #1;
        check("mid_rst_level",   32'(bus.level),    0);
        check("mid_rst_valid",   32'(bus.resValid), 0);
        check("mid_rst_sum",     32'(bus.resSum),   0);
        check("mid_rst_opReady", 32'(bus.opReady),  1);
        check("mid_rst_addIn1",  32'(bus.addIn1),   0);
        step();
        rstN = 1'b1;
        bus.resReady = 1'b1;
        step();
        step();
        check("mid_post_valid", 32'(bus.resValid), 0);
        check("mid_post_level", 32'(bus.level),    0);

        // ---------------- streaming with random handshakes ----------------
        pushed = 0;
        got    = 0;
        cyc    = 0;
        while ((pushed < N_STREAM || exp_q.size() != 0) && cyc < MAX_CYCLES) begin
            bus.opValid  = (pushed < N_STREAM) && ($urandom_range(0, 3) != 0);
            bus.opA      = W'($urandom_range(0, 3));
            bus.opB      = W'($urandom_range(0, 3));
            bus.resReady = ($urandom_range(0, 2) != 0);
            if (bus.resValid && bus.resReady) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 32'(bus.resValid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_sum", 32'(bus.resSum), 32'(e % 4));
`ifdef ADD2_OVERFLOW_FLAG_EN
                    check("stream_ovf", 32'(bus.resOvf), (e >= 4) ? 1 : 0);
`endif
                    got++;
                end
            end
            if (bus.opValid && bus.opReady) begin
                exp_q.push_back(int'(bus.opA) + int'(bus.opB));
                pushed++;
            end
            step();
            cyc++;
        end
        bus.opValid  = 1'b0;
        bus.resReady = 1'b0;
        check("stream_pushed",  32'(pushed),       32'(N_STREAM));
        check("stream_got",     32'(got),          32'(N_STREAM));
        check("stream_pending", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
